// File: rtl/rc4_crack_core.sv
// RC4 brute-force search engine. For each candidate key it rebuilds S, runs KSA and PRGA,
// decrypts the ciphertext ROM into the output RAM, and rejects the key on the first byte that
// falls outside the accepted character set. Keys advance by a programmable stride so several
// cores can split one keyspace.
module rc4_crack_core #(
  parameter int unsigned KEY_BYTES   = 3,
  parameter int unsigned MSG_LEN     = 32,
  parameter logic [7:0]  CHAR_LO     = 8'h61,
  parameter logic [7:0]  CHAR_HI     = 8'h7A,
  parameter bit          ALLOW_SPACE = 1'b1,
  localparam int unsigned KW = 8 * KEY_BYTES,
  localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_first,
  input  logic [KW-1:0] key_last,
  input  logic [KW-1:0] key_stride,
  input  logic          abort,
  input  logic          done_ack,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_q,
  output logic          dec_wren,
  output logic [AW-1:0] dec_addr,
  output logic [7:0]    dec_data,
  output logic [KW-1:0] cur_key,
  output logic          busy,
  output logic          done,
  output logic          found
);

  typedef enum logic [2:0] {StIdle, StInit, StKsa, StPrga, StNext, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    s_q [256];
  logic [7:0]    i_q, j_q, k_q;
  logic [1:0]    ph_q;
  logic [KW-1:0] cur_key_q, key_last_q, stride_q;
  // Copy of cur_key rotated one byte per KSA step; its top byte is keybyte(i).
  logic [KW-1:0] key_sh_q;
  logic          found_q;
  logic [AW-1:0] rom_addr_q;

  logic [7:0]    si, sj, ks_idx, out_byte, key_byte;
  logic          byte_ok, last_byte, prga_out, hit, key_end, busy_w;
  logic [KW:0]   sum;

  assign si        = s_q[i_q];
  assign sj        = s_q[j_q];
  assign ks_idx    = si + sj;
  assign out_byte  = s_q[ks_idx] ^ rom_q;
  assign key_byte  = key_sh_q[KW-1 -: 8];
  assign byte_ok   = ((out_byte >= CHAR_LO) && (out_byte <= CHAR_HI)) ||
                     (ALLOW_SPACE && (out_byte == 8'h20));
  assign last_byte = (k_q == 8'(MSG_LEN - 1));
  assign prga_out  = (state_q == StPrga) && (ph_q == 2'd3);
  assign hit       = prga_out && byte_ok && last_byte;
  assign sum       = {1'b0, cur_key_q} + {1'b0, stride_q};
  assign key_end   = sum[KW] || (sum[KW-1:0] > key_last_q);
  assign busy_w    = (state_q == StInit) || (state_q == StKsa) ||
                     (state_q == StPrga) || (state_q == StNext);

  assign busy     = busy_w;
  assign done     = (state_q == StDone);
  assign found    = found_q;
  assign cur_key  = cur_key_q;
  assign rom_addr = rom_addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode and RAM write-port outputs.
  always_comb begin
    state_d  = state_q;
    dec_wren = 1'b0;
    dec_addr = '0;
    dec_data = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StInit;
      StInit: if (i_q == 8'hFF) state_d = StKsa;
      StKsa:  if (ph_q[0] && (i_q == 8'hFF)) state_d = StPrga;
      StPrga: begin
        if (prga_out) begin
          dec_wren = 1'b1;
          dec_addr = k_q[AW-1:0];
          dec_data = out_byte;
          if (!byte_ok)      state_d = StNext;
          else if (last_byte) state_d = StDone;
        end
      end
      StNext: state_d = key_end ? StDone : StInit;
      StDone: if (done_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A complete valid message in the same cycle outranks abort.
    if (abort && busy_w && !hit) state_d = StDone;
  end

  // Datapath: S array, RC4 indices, key stepping and the found flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 256; n++) s_q[n] <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      ph_q       <= '0;
      cur_key_q  <= '0;
      key_last_q <= '0;
      stride_q   <= '0;
      key_sh_q   <= '0;
      found_q    <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_key_q  <= key_first;
            key_last_q <= key_last;
            stride_q   <= key_stride;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            ph_q       <= '0;
            found_q    <= 1'b0;
          end
        end
        StInit: begin
          s_q[i_q] <= i_q;
          i_q      <= i_q + 8'd1;
          j_q      <= '0;
          ph_q     <= '0;
          key_sh_q <= cur_key_q;
        end
        StKsa: begin
          if (!ph_q[0]) begin
            j_q  <= j_q + si + key_byte;
            ph_q <= 2'd1;
          end else begin
            s_q[i_q] <= sj;
            s_q[j_q] <= si;
            i_q      <= i_q + 8'd1;
            ph_q     <= 2'd0;
            key_sh_q <= (key_sh_q << 8) | (key_sh_q >> (KW - 8));
            // PRGA starts with i = j = 0; i wraps to 0 on its own.
            if (i_q == 8'hFF) j_q <= '0;
          end
        end
        StPrga: begin
          ph_q <= ph_q + 2'd1;
          unique case (ph_q)
            2'd0: i_q <= i_q + 8'd1;
            2'd1: j_q <= j_q + si;
            2'd2: begin
              s_q[i_q]   <= sj;
              s_q[j_q]   <= si;
              rom_addr_q <= k_q[AW-1:0];
            end
            2'd3: begin
              if (byte_ok && !last_byte) k_q <= k_q + 8'd1;
              if (hit) found_q <= 1'b1;
            end
            default: ;
          endcase
        end
        StNext: begin
          // Only advance when another key will really be tried, so cur_key keeps the last one.
          if (state_d == StInit) begin
            cur_key_q <= sum[KW-1:0];
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            ph_q      <= '0;
          end
        end
        StDone: if (done_ack) found_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_crack_core.sv
// Bench for rc4_crack_core: directed scenarios plus randomized key searches, checked against a
// plain-arithmetic RC4 model and a key-search model.
module tb_rc4_crack_core;

  localparam int ML = 32;
  localparam int KB = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, done_ack;
  logic [23:0] key_first, key_last, key_stride;
  logic [4:0]  rom_addr, dec_addr;
  logic [7:0]  rom_q, dec_data;
  logic        dec_wren, busy, done, found;
  logic [23:0] cur_key;

  logic [7:0]  rom [0:ML-1];
  logic [7:0]  ram [0:ML-1];
  logic [7:0]  ks  [0:ML-1];
  logic [7:0]  pt  [0:ML-1];

  int checks = 0;
  int errors = 0;

  rc4_crack_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_first  (key_first),
    .key_last   (key_last),
    .key_stride (key_stride),
    .abort      (abort),
    .done_ack   (done_ack),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .dec_wren   (dec_wren),
    .dec_addr   (dec_addr),
    .dec_data   (dec_data),
    .cur_key    (cur_key),
    .busy       (busy),
    .done       (done),
    .found      (found)
  );

  always #5 clk = ~clk;

  assign rom_q = rom[rom_addr];

  always @(posedge clk) if (dec_wren) ram[dec_addr] <= dec_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard RC4 keystream for a KB-byte key, first ML bytes.
  task automatic model_ks(input logic [23:0] key);
    int s[256];
    int j, t, ii, kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = int'((key >> (8 * (KB - 1 - (n % KB)))) & 24'hFF);
      j = (j + s[n] + kb) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    ii = 0;
    j = 0;
    for (int n = 0; n < ML; n++) begin
      ii = (ii + 1) % 256;
      j = (j + s[ii]) % 256;
      t = s[ii]; s[ii] = s[j]; s[j] = t;
      ks[n] = 8'(s[(s[ii] + s[j]) % 256]);
    end
  endtask

  function automatic bit ok_char(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Walk the key sequence; leaves ks holding the keystream of the last key examined.
  task automatic model_search(input longint first, input longint last, input longint stride,
                              output bit f, output longint key);
    bit good;
    f = 1'b0;
    key = first;
    for (int n = 0; n < 64; n++) begin
      model_ks(key[23:0]);
      good = 1'b1;
      for (int m = 0; m < ML; m++) if (!ok_char(rom[m] ^ ks[m])) good = 1'b0;
      if (good) begin
        f = 1'b1;
        return;
      end
      if ((key + stride > 64'hFFFFFF) || (key + stride > last)) return;
      key = key + stride;
    end
  endtask

  task automatic load_rom(input logic [23:0] key);
    model_ks(key);
    for (int m = 0; m < ML; m++) rom[m] = pt[m] ^ ks[m];
  endtask

  task automatic go(input logic [23:0] first, input logic [23:0] last, input logic [23:0] stride);
    key_first = first;
    key_last = last;
    key_stride = stride;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_key", cur_key, first);
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("ack_done", done, 0);
    check("ack_busy", busy, 0);
    check("ack_found", found, 0);
    check("ack_wren", dec_wren, 0);
  endtask

  task automatic run_search(input logic [23:0] first, input logic [23:0] last,
                            input logic [23:0] stride);
    bit     ef;
    longint ek;
    int     cyc;
    model_search(first, last, stride, ef, ek);
    go(first, last, stride);
    cyc = 0;
    while (!done && cyc < 12000) begin
      tick();
      cyc++;
    end
    check("done", done, 1);
    check("found", found, 32'(ef));
    check("cur_key", cur_key, ek[23:0]);
    if (ef) for (int m = 0; m < ML; m++) check("ram", ram[m], rom[m] ^ ks[m]);
    ack();
  endtask

  initial begin
    int n, cnt, bad, r;
    logic [23:0] tgt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; done_ack = 1'b0;
    key_first = '0; key_last = '0; key_stride = '0;
    for (int m = 0; m < ML; m++) begin
      pt[m] = 8'h61;
      ram[m] = 8'h00;
    end
    load_rom(24'h000003);
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_wren", dec_wren, 0);
    check("rst_key", cur_key, 0);
    check("rst_romaddr", rom_addr, 0);

    // Reset in the middle of KSA.
    go(24'h0, 24'h5, 24'h1);
    repeat (300) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_found", found, 0);
    check("midrst_wren", dec_wren, 0);
    check("midrst_key", cur_key, 0);

    // Hit, exhaust, stride, stride with wrap.
    run_search(24'h0, 24'h5, 24'h1);
    run_search(24'h4, 24'h9, 24'h1);
    run_search(24'h1, 24'hFFFFFF, 24'h2);
    run_search(24'hFFFFFA, 24'hFFFFFF, 24'h2);

    // Abort in the middle of PRGA, coinciding with the first written byte.
    go(24'h3, 24'h3, 24'h1);
    n = 0;
    while (!dec_wren && n < 2000) begin
      tick();
      n++;
    end
    check("abort_wr", dec_wren, 1);
    check("wr_addr0", dec_addr, 0);
    check("wr_data0", dec_data, 8'h61);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", done, 1);
    check("abort_found", found, 0);
    check("abort_key", cur_key, 24'h3);
    ack();

    // Abort coinciding with the final valid byte: found wins.
    go(24'h3, 24'h3, 24'h1);
    cnt = 0;
    n = 0;
    while (cnt < ML && n < 3000) begin
      tick();
      n++;
      if (dec_wren) cnt++;
    end
    check("last_wr", dec_wren, 1);
    check("last_addr", dec_addr, ML - 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abortlast_done", done, 1);
    check("abortlast_found", found, 1);

    // done/found hold while start pulses and done_ack stays low.
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      start = (c % 7 == 0);
      tick();
      if (!done || !found || busy || dec_wren) bad++;
    end
    start = 1'b0;
    check("hold_bad_cycles", bad, 0);
    check("hold_key", cur_key, 24'h3);
    ack();

    // Randomized messages and key windows.
    for (int it = 0; it < 3; it++) begin
      for (int m = 0; m < ML; m++) begin
        r = $urandom_range(0, 26);
        pt[m] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
      tgt = 24'($urandom_range(16, 32'hFFFFF0));
      load_rom(tgt);
      run_search(tgt - 24'($urandom_range(0, 3)), tgt + 24'($urandom_range(0, 2)),
                 24'($urandom_range(1, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
